// File: rtl/acc_seq_pkg.sv
// Shared encodings for the accumulator sequencer: opcodes, FSM states, default widths.
// Optional build macro consumed by the top: ACC_SEQ_CTRL_TIMEOUT_EN.
package acc_seq_pkg;

    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 15;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_WB     = 3'd4,
        ST_STORE  = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// Memory request/ack bus between the sequencer (master) and the shared 32-byte memory (slave).
interface acc_seq_ctrl_if
    import acc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, mem_rd, mem_wr, input mem_ack, mem_rdata);
    modport slave  (input mem_addr, mem_rd, mem_wr, output mem_ack, mem_rdata);
endinterface

// File: rtl/acc_seq_wdog.sv
// Wait-cycle watchdog: counts cycles a request goes unanswered and flags the LIMIT-th one.
module acc_seq_wdog #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires combinationally on the LIMIT-th unacked cycle so the FSM can halt on that edge.
    assign expire = enable && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expire)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/acc_seq_ctrl.sv
// Multicycle Moore sequencer for the 8-bit accumulator datapath.
// Define ACC_SEQ_CTRL_TIMEOUT_EN to build the mem_ack watchdog and the sticky err flag.
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    acc_seq_ctrl_if.master     mem,
    output logic [2:0]         alu_op,
    output logic               acc_update,
    input  logic               acc_zero,
    output logic [ADDR_W-1:0]  pc,
    output logic [DATA_W-1:0]  ir,
    output logic               halted,
    output logic               err
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        opc;
    logic              waiting, ack, tmo;

    assign opc     = ir_q[DATA_W-1 -: 3];
    assign waiting = (state_q == ST_FETCH) || (state_q == ST_READ) || (state_q == ST_STORE);
    assign ack     = mem.mem_ack && waiting;

    // Strobes are pure state decodes; the datapath captures mem_rdata itself on the READ ack.
    assign mem.mem_rd  = (state_q == ST_FETCH) || (state_q == ST_READ);
    assign mem.mem_wr  = (state_q == ST_STORE);
    assign mem.mem_addr = (state_q == ST_FETCH) ? pc_q :
                          (state_q == ST_READ || state_q == ST_STORE) ? ir_q[ADDR_W-1:0] :
                          '0;
    assign alu_op      = (state_q == ST_WB) ? opc : 3'b000;
    assign acc_update  = (state_q == ST_WB);
    assign halted      = (state_q == ST_HALT);
    assign pc          = pc_q;
    assign ir          = ir_q;

`ifdef ACC_SEQ_CTRL_TIMEOUT_EN
    logic err_q, err_d;

    acc_seq_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (!waiting || ack),
        .enable (waiting && !ack),
        .expire (tmo)
    );

    assign err_d = err_q | tmo;
    assign err   = err_q;

    always_ff @(posedge clock) begin
        if (!reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (ack) begin
                ir_d    = mem.mem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: case (opc)
                OP_NOP: state_d = ST_FETCH;
                OP_HLT: state_d = ST_HALT;
                OP_STA: state_d = ST_STORE;
                OP_JZ: begin
                    if (acc_zero)
                        pc_d = ir_q[ADDR_W-1:0];
                    state_d = ST_FETCH;
                end
                default: state_d = ST_READ;
            endcase
            ST_READ:  if (ack) state_d = ST_WB;
            ST_WB:    state_d = ST_FETCH;
            ST_STORE: if (ack) state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
        if (tmo)
            state_d = ST_HALT;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl: memory with programmable ack delay plus an accumulator/ALU model.
module tb_acc_seq_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] alu_op;
    logic       acc_update;
    logic       acc_zero = 1'b0;
    logic [4:0] pc;
    logic [7:0] ir;
    logic       halted;
    logic       err;

    logic [7:0] mem [32];
    logic       ack_en = 1'b0;
    logic       ack_force = 1'b0;
    int         ack_dly = 0;
    int         wait_cnt = 0;
    logic [7:0] acc = 8'h00;
    logic [7:0] opnd = 8'h00;
    int         wr_cnt = 0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    acc_seq_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    acc_seq_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .mem        (bus.master),
        .alu_op     (alu_op),
        .acc_update (acc_update),
        .acc_zero   (acc_zero),
        .pc         (pc),
        .ir         (ir),
        .halted     (halted),
        .err        (err)
    );

    always #5 clock = ~clock;

    assign bus.mem_ack   = ack_force | (ack_en && (bus.mem_rd || bus.mem_wr) && (wait_cnt >= ack_dly));
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Memory wait counter, operand capture, accumulator/ALU model and write log.
    always @(posedge clock) begin
        if ((bus.mem_rd || bus.mem_wr) && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.mem_rd && bus.mem_ack) opnd <= bus.mem_rdata;
        if (bus.mem_wr && bus.mem_ack) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_addr;
            wr_data <= acc;
        end
        if (!reset) acc <= 8'h00;
        else if (acc_update) begin
            case (alu_op)
                3'b001: acc <= opnd;
                3'b010: acc <= acc + opnd;
                3'b011: acc <= acc - opnd;
                3'b100: acc <= acc & opnd;
                default: acc <= acc;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        int         cyc;
        logic [2:0] ops [$];
        clr_mem();

        // Reset state, then reset in the middle of a stalled FETCH
        repeat (2) tick();
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_rd", bus.mem_rd, 0);
        chk("rst_wr", bus.mem_wr, 0);
        chk("rst_upd", acc_update, 0);
        chk("rst_halt", halted, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        tick();
        chk("fetch_rd", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd0});
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("midrst_rd", bus.mem_rd, 0);
        chk("midrst_pcir", {pc, ir}, 0);
        ack_force = 1'b1;
        reset = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("late_ack_ignored", {pc, ir}, 0);
        chk("rd_after_release", bus.mem_rd, 1);

        // Program LDA 0x10, ADD 0x11, STA 0x12, HLT with zero-wait memory
        clr_mem();
        mem[0] = 8'h30; mem[1] = 8'h51; mem[2] = 8'hB2; mem[3] = 8'hE0;
        mem[16] = 8'h05; mem[17] = 8'h03;
        ack_en = 1'b1; ack_dly = 0;
        do_reset();
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (acc_update) ops.push_back(alu_op);
            if (halted) begin cyc = c; break; end
        end
        chk("prog_cycles", cyc, 14);
        chk("prog_nupd", ops.size(), 2);
        if (ops.size() == 2) begin
            chk("prog_op0", ops[0], 3'b001);
            chk("prog_op1", ops[1], 3'b010);
        end
        chk("prog_acc", acc, 8'h08);
        chk("prog_wr", {wr_cnt[7:0], 3'b000, wr_addr, wr_data}, {8'd1, 3'b000, 5'h12, 8'h08});
        chk("prog_halt_pc", {halted, pc}, {1'b1, 5'd4});
        chk("prog_ir", ir, 8'hE0);
        tick();
        chk("halt_stays", {halted, bus.mem_rd, bus.mem_wr, pc}, {3'b100, 5'd4});

        // JZ 0x1F taken, then NOP at 31 wraps pc to 0
        clr_mem();
        mem[0] = 8'hDF; mem[31] = 8'h00; mem[1] = 8'hE0;
        acc_zero = 1'b1;
        do_reset();
        repeat (3) tick();
        chk("jz_taken_pc", pc, 5'h1F);
        chk("jz_taken_fetch", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'h1F});
        tick();
        chk("wrap_pc", {pc, ir}, {5'd0, 8'h00});
        tick();
        chk("wrap_fetch", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd0});

        // JZ 0x1F not taken
        acc_zero = 1'b0;
        do_reset();
        repeat (3) tick();
        chk("jz_not_taken_pc", pc, 5'd1);
        chk("jz_not_taken_fetch", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd1});

        // Three-cycle ack delay on FETCH
        clr_mem();
        mem[0] = 8'h00; mem[1] = 8'hE0;
        ack_dly = 3;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dly_hold%0d", k), {bus.mem_rd, bus.mem_addr, pc}, {1'b1, 5'd0, 5'd0});
            tick();
        end
        chk("dly_decode", {bus.mem_rd, pc, ir}, {1'b0, 5'd1, 8'h00});
        tick();
        chk("dly_next_fetch", {bus.mem_rd, bus.mem_addr, pc}, {1'b1, 5'd1, 5'd1});
        ack_dly = 0;

        // Ack withheld in READ
        clr_mem();
        mem[0] = 8'h30;
        ack_en = 1'b1;
        do_reset();
        repeat (2) tick();
        ack_en = 1'b0;
        tick();
        chk("read_enter", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'h10});
        cyc = 0;
`ifdef ACC_SEQ_CTRL_TIMEOUT_EN
        repeat (14) begin tick(); if (acc_update) cyc++; end
        chk("tmo_before", {err, halted, bus.mem_rd}, 3'b001);
        tick();
        chk("tmo_expired", {err, halted, bus.mem_rd}, 3'b110);
        chk("tmo_no_upd", cyc, 0);
        do_reset();
        chk("tmo_err_cleared", err, 0);
`else
        repeat (100) begin tick(); if (acc_update) cyc++; end
        chk("no_tmo_still_read", {err, halted, bus.mem_rd, bus.mem_addr}, {3'b001, 5'h10});
        chk("no_tmo_no_upd", cyc, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
Multicycle Moore sequencer that drives the 8-bit accumulator datapath: the ALU and the accumulator register with its update strobe.
- Fetches 8-bit instructions from a shared 32-byte memory over a req/ack handshake.
- Decodes each instruction as opcode[7:5] and operand address[4:0].
- Sequences operand reads, ALU operation select, accumulator update and stores.
- Sits between the memory and the ALU/accumulator pair as the only master of both.

Parameters:
ADDR_W, 5, memory address width; also the PC width.
DATA_W, 8, instruction, data and accumulator width.
TIMEOUT_CYC, 15, maximum wait cycles for mem_ack; used only when ACC_SEQ_CTRL_TIMEOUT_EN is defined.

Ports:
clock  in  1  system clock; all state changes on posedge.
reset  in  1  synchronous, active-low reset.
mem_addr  out  ADDR_W  memory address: pc in FETCH, ir[4:0] in READ/STORE, 0 otherwise.
mem_rd  out  1  read request, held until ack.
mem_wr  out  1  write request of the accumulator value, held until ack.
mem_ack  in  1  memory completion; rdata is valid in the same cycle.
mem_rdata  in  DATA_W  read data.
alu_op  out  3  ALU select; equals ir[7:5] in WB, 000 otherwise.
acc_update  out  1  single-cycle accumulator load strobe.
acc_zero  in  1  accumulator value equals 0.
pc  out  ADDR_W  program counter.
ir  out  DATA_W  instruction register.
halted  out  1  high in HALT.
err  out  1  sticky timeout flag; constant 0 when the macro is undefined.

Behaviour:
Reset:
- On any posedge with reset=0: state=IDLE, pc=0, ir=0, err=0.
- All strobes are decoded from state, so mem_rd, mem_wr, acc_update and halted are 0 in the cycle after reset.
- Reset mid-handshake abandons the transaction; a late mem_ack is ignored.

Opcodes:
- 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 AND, 101 STA, 110 JZ, 111 HLT.

States and transitions:
- IDLE: no outputs asserted -> FETCH next cycle.
- FETCH: mem_rd=1, mem_addr=pc.
  - On mem_ack: ir<=mem_rdata, pc<=pc+1 (wraps 31->0) -> DECODE.
  - Without ack: stay in FETCH.
- DECODE (1 cycle):
  - NOP -> FETCH.
  - HLT -> HALT.
  - JZ: if acc_zero=1 then pc<=ir[4:0]; -> FETCH. acc_zero is sampled in this cycle.
  - LDA/ADD/SUB/AND -> READ.
  - STA -> STORE.
- READ: mem_rd=1, mem_addr=ir[4:0] -> WB on mem_ack.
  - mem_rdata is registered as the ALU operand.
- WB: acc_update=1 and alu_op=ir[7:5] for exactly one cycle -> FETCH.
- STORE: mem_wr=1, mem_addr=ir[4:0] -> FETCH on mem_ack.
- HALT: halted=1; stays in HALT until reset.

Handshake and timing:
- mem_ack is ignored unless mem_rd or mem_wr is high.
- Zero-wait ack (ack in the first request cycle) is legal and completes the transaction in that cycle.
- mem_rd and mem_wr are never high together.
- Instruction latency with zero-wait memory:
  - NOP and JZ: 2 cycles.
  - STA: 3 cycles.
  - LDA/ADD/SUB/AND: 4 cycles.

Optional Feature:
ACC_SEQ_CTRL_TIMEOUT_EN
- Defined: a wait counter clears on entry to FETCH, READ or STORE and increments each cycle without ack.
  - When the count reaches TIMEOUT_CYC with no ack: err<=1 and the FSM goes to HALT.
  - An ack in the same cycle as the timeout wins, and the transaction completes normally.
- Undefined: no counter is built, err is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Package acc_seq_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - state encoding ST_IDLE, ST_FETCH, ST_DECODE, ST_READ, ST_WB, ST_STORE, ST_HALT (3-bit);
  - default widths.
- One sub-module, acc_seq_wdog: the timeout counter with clear/enable/expire ports, instantiated only under the macro.

Test Plan:
- Reset low for 2 cycles mid-FETCH -> next cycle state IDLE, pc=0, ir=0, mem_rd=0; mem_rd=1 two cycles after release.
- Program LDA 0x10, ADD 0x11, STA 0x12, HLT with mem[0x10]=0x05, mem[0x11]=0x03, zero-wait ack -> acc_update pulses with alu_op 001 then 010; write of 0x08 to 0x12; halted=1 with pc=4.
- JZ 0x1F at pc=0, with acc_zero=1 and then, after reset, acc_zero=0 -> pc=0x1F in the first run, pc=1 in the second.
- mem_ack delayed 3 cycles on each request -> mem_rd held stable for 4 cycles with mem_addr unchanged, and no extra pc increment.
- NOP at address 31 -> pc wraps to 0 and the next fetch uses mem_addr=0.
- With macro defined, ack withheld in READ -> err=1 and halted=1 after 15 wait cycles; acc_update never asserted. Without macro -> FSM still in READ after 100 cycles.
